// File: rtl/cv32e40p_illegal_insn_trace_if.sv
// Bundle of the ID-stage event inputs and the trace output stream for
// cv32e40p_illegal_insn_trace. The slave modport is the trace unit itself;
// the master modport is the surrounding core / consumer.
interface cv32e40p_illegal_insn_trace_if #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned OVF_W = 16
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic              is_decoding_i;
  logic              illegal_insn_dec_i;
  logic [31:0]       hart_id_i;
  logic [31:0]       pc_id_i;
  logic              trace_valid_o;
  logic              trace_ready_i;
  logic [31:0]       trace_pc_o;
  logic [3:0]        trace_hart_o;
  logic [31:0]       trace_ts_o;
  logic [CW-1:0]     count_o;
  logic [OVF_W-1:0]  overflow_cnt_o;

  modport slave (
    input  is_decoding_i, illegal_insn_dec_i, hart_id_i, pc_id_i, trace_ready_i,
    output trace_valid_o, trace_pc_o, trace_hart_o, trace_ts_o, count_o, overflow_cnt_o
  );

  modport master (
    output is_decoding_i, illegal_insn_dec_i, hart_id_i, pc_id_i, trace_ready_i,
    input  trace_valid_o, trace_pc_o, trace_hart_o, trace_ts_o, count_o, overflow_cnt_o
  );
endinterface

// File: rtl/cv32e40p_illegal_insn_trace.sv
// Illegal-instruction trace buffer: every cycle the ID stage decodes an
// illegal instruction, {pc, hart[3:0], timestamp} is pushed into a small
// FIFO drained through a valid/ready stream. Events arriving while the FIFO
// is full (and not popping) are dropped and counted in a saturating counter.
// Optional feature macro: CV32E40P_ILLEGAL_TRACE_TIMESTAMP_EN adds a 32-bit
// free-running cycle counter whose value is stored with each record; without
// it the timestamp output is tied to zero.
module cv32e40p_illegal_insn_trace #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned OVF_W = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  cv32e40p_illegal_insn_trace_if.slave  bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [31:0]      r_mem_pc   [DEPTH];
  logic [3:0]       r_mem_hart [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic [OVF_W-1:0] r_ovf;

  logic w_event;
  logic w_valid;
  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_drop;
  logic w_unused_hart;

  assign w_event = bus.is_decoding_i & bus.illegal_insn_dec_i;
  assign w_valid = (r_count != '0);
  assign w_full  = (r_count == FULL_CNT);
  assign w_pop   = w_valid & bus.trace_ready_i;
  // When full, a same-edge pop frees the head slot, so the push may reuse it.
  assign w_push  = w_event & (~w_full | w_pop);
  assign w_drop  = w_event & w_full & ~w_pop;

  assign w_unused_hart = ^bus.hart_id_i[31:4];

  // Pointer, occupancy and drop-counter state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovf   <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_drop && (r_ovf != '1)) r_ovf <= r_ovf + 1'b1;
    end
  end

  // Record storage; contents are only ever observed through the valid gate.
  always_ff @(posedge clk_i) begin
    if (w_push && !rst_i) begin
      r_mem_pc[r_wptr]   <= bus.pc_id_i;
      r_mem_hart[r_wptr] <= bus.hart_id_i[3:0];
    end
  end

`ifdef CV32E40P_ILLEGAL_TRACE_TIMESTAMP_EN
  logic [31:0] r_ts;
  logic [31:0] r_mem_ts [DEPTH];

  // Free-running cycle counter, wraps naturally at 32 bits.
  always_ff @(posedge clk_i) begin
    if (rst_i) r_ts <= '0;
    else       r_ts <= r_ts + 32'd1;
  end

  // Timestamp storage alongside each record.
  always_ff @(posedge clk_i) begin
    if (w_push && !rst_i) r_mem_ts[r_wptr] <= r_ts;
  end

  assign bus.trace_ts_o = w_valid ? r_mem_ts[r_rptr] : '0;
`else
  assign bus.trace_ts_o = '0;
`endif

  assign bus.trace_valid_o  = w_valid;
  assign bus.trace_pc_o     = w_valid ? r_mem_pc[r_rptr]   : '0;
  assign bus.trace_hart_o   = w_valid ? r_mem_hart[r_rptr] : '0;
  assign bus.count_o        = r_count;
  assign bus.overflow_cnt_o = r_ovf;
endmodule
